// File: rtl/inv_rho_serial.sv
// Serial inverse-rho: collects a word beat by beat, mixes each column with the column parity, and streams the result back out.
// Latency: 1 XFORM cycle between the last input beat and out_valid. Backpressure: out_col and beat count hold while out_valid && !out_ready.
module inv_rho_serial #(
    parameter int BLOCK_SIZE  = 64,
    parameter int SIDE_SIZE   = BLOCK_SIZE / 2,
    parameter int COLUMN_SIZE = SIDE_SIZE / 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:COLUMN_SIZE-1] in_col,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:COLUMN_SIZE-1] out_col,
    output logic                   busy
);

    localparam int         NUM_COLS  = SIDE_SIZE / COLUMN_SIZE;
    localparam logic [1:0] LAST_BEAT = 2'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        XFORM = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             beat_cnt;
    logic [0:SIDE_SIZE-1]   in_word;
    logic [0:SIDE_SIZE-1]   out_word;
    logic [0:SIDE_SIZE-1]   inv_word;
    logic [0:COLUMN_SIZE-1] col_par;

    // rho XORs the parity of all columns into every column; with an even
    // column count the parity of the result equals the original parity, so
    // applying the same mix again recovers the input.
    always_comb begin
        col_par  = '0;
        inv_word = '0;
        for (int k = 0; k < NUM_COLS; k++) begin
            col_par = col_par ^ in_word[k*COLUMN_SIZE +: COLUMN_SIZE];
        end
        for (int k = 0; k < NUM_COLS; k++) begin
            inv_word[k*COLUMN_SIZE +: COLUMN_SIZE] = in_word[k*COLUMN_SIZE +: COLUMN_SIZE] ^ col_par;
        end
    end

    assign out_col = out_word[0:COLUMN_SIZE-1];
    assign busy    = (state != LOAD) || (beat_cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            beat_cnt  <= 2'd0;
            in_word   <= '0;
            out_word  <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_word <= {in_word[COLUMN_SIZE:SIDE_SIZE-1], in_col};
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt <= 2'd0;
                            in_ready <= 1'b0;
                            state    <= XFORM;
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                XFORM: begin
                    out_word  <= inv_word;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        out_word <= {out_word[COLUMN_SIZE:SIDE_SIZE-1], {COLUMN_SIZE{1'b0}}};
                        if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= 2'd0;
                            out_valid <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= LOAD;
                        end else begin
                            beat_cnt <= beat_cnt + 2'd1;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    beat_cnt  <= 2'd0;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_rho_serial.sv
// Bench for inv_rho_serial: directed known-vector, latency, stall, gap and reset steps, then random round trips.
module tb_inv_rho_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [0:7] in_col;
    logic       out_valid;
    logic       out_ready;
    logic [0:7] out_col;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] KNOWN_IN  = 32'hed342fd3;
    localparam logic [31:0] KNOWN_OUT = 32'hc8110af6;

    inv_rho_serial dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_col    (in_col),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Forward rho: every byte gets the XOR of all four bytes mixed in.
    function automatic logic [31:0] rho(input logic [31:0] x);
        logic [7:0] p;
        p = x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0];
        return x ^ {4{p}};
    endfunction

    function automatic logic [7:0] beat_of(input logic [31:0] w, input int k);
        return w[31-8*k -: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives the four beats of w from a negedge, optionally idling before beat gap_beat.
    task automatic feed(input logic [31:0] w, input int gap_beat, input int gap_len, input string tag);
        bit rdy_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == gap_beat) begin
                repeat (gap_len) begin
                    in_valid = 1'b0;
                    in_col   = 8'($urandom);
                    @(negedge clk);
                    if (in_ready !== 1'b1) rdy_ok = 1'b0;
                end
            end
            if (in_ready !== 1'b1) rdy_ok = 1'b0;
            in_valid = 1'b1;
            in_col   = beat_of(w, k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check({tag, "_in_ready_load"}, 32'(rdy_ok), 32'd1);
    endtask

    // Collects four output beats, stalling stall_len cycles on beat stall_beat.
    task automatic collect(input logic [31:0] exp, input int stall_beat, input int stall_len, input string tag);
        logic [31:0] acc = '0;
        bit hold_ok = 1'b1;
        int t;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (k == stall_beat) begin
                out_ready = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_col !== beat_of(exp, k)) hold_ok = 1'b0;
                end
            end
            acc[31-8*k -: 8] = out_col;
            out_ready = 1'b1;
            in_valid  = 1'($urandom_range(1));
            in_col    = 8'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_word"}, acc, exp);
        if (stall_len > 0) check({tag, "_hold"}, 32'(hold_ok), 32'd1);
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic xfer_rand(input logic [31:0] din, input logic [31:0] exp, input int pct, input string tag);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        logic [31:0] acc = '0;
        bit rdy_ok = 1'b1;
        while (got < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sent < 4) begin
                if (in_ready !== 1'b1) rdy_ok = 1'b0;
                in_valid = ($urandom_range(99) < pct);
                in_col   = beat_of(din, sent);
                if (in_valid && in_ready) sent++;
            end else begin
                in_valid = 1'($urandom_range(1));
                in_col   = 8'($urandom);
            end
            out_ready = ($urandom_range(99) < pct);
            if (out_valid && out_ready) begin
                acc[31-8*got -: 8] = out_col;
                got++;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_beats"}, 32'(got), 32'd4);
        check({tag, "_word"}, acc, exp);
        check({tag, "_in_ready_load"}, 32'(rdy_ok), 32'd1);
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_col    = '0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_col", 32'(out_col), 32'd0);
        in_valid = 1'b1;
        in_col   = 8'h5a;
        repeat (2) @(negedge clk);
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        check("rst_hold_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);
        check("rel_busy", 32'(busy), 32'd0);

        // Known vector with exact timing: after the 4th accepting edge N the
        // block sits in XFORM, and beat 0 is presented for the edge N+2.
        feed(KNOWN_IN, -1, 0, "kv");
        check("kv_xform_out_valid", 32'(out_valid), 32'd0);
        check("kv_xform_in_ready", 32'(in_ready), 32'd0);
        check("kv_xform_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("kv_send_out_valid", 32'(out_valid), 32'd1);
        check("kv_send_beat0", 32'(out_col), 32'h0000_00c8);
        collect(KNOWN_OUT, -1, 0, "kv");

        feed(KNOWN_IN, -1, 0, "bp");
        collect(KNOWN_OUT, 2, 3, "bp");

        feed(KNOWN_IN, 2, 2, "gap");
        collect(KNOWN_OUT, -1, 0, "gap");

        // Reset part-way through SEND, after two output handshakes.
        feed(KNOWN_IN, -1, 0, "rs");
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        #2 rst_n  = 1'b0;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_out_col", 32'(out_col), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
        check("rs_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rs_rel_in_ready", 32'(in_ready), 32'd1);
        feed(KNOWN_IN, -1, 0, "rs2");
        collect(KNOWN_OUT, -1, 0, "rs2");

        // Reset part-way through LOAD discards the partial word.
        in_valid = 1'b1;
        in_col   = 8'h77;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rl_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        feed(KNOWN_IN, -1, 0, "rl");
        collect(KNOWN_OUT, -1, 0, "rl");

        xfer_rand(rho(32'h0000_0000), 32'h0000_0000, 100, "zero");
        xfer_rand(rho(32'hffff_ffff), 32'hffff_ffff, 100, "ones");

        for (int i = 0; i < 1000; i++) begin
            logic [31:0] x;
            x = $urandom;
            xfer_rand(rho(x), x, 50, "rt");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
